// File: rtl/fetch_pkg.sv
// Shared types for the instruction prefetcher: fetch FSM states and queue entry layout.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/wishbone_if.sv
// Wishbone classic bus bundle; data_in is master-to-slave, data_out is slave-to-master.
interface wishbone_if;

    logic        cycle;
    logic        strobe;
    logic        write_enable;
    logic [3:0]  select;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;

    modport master (
        output cycle, strobe, write_enable, select, address, data_in,
        input  data_out, ack
    );

    modport slave (
        input  cycle, strobe, write_enable, select, address, data_in,
        output data_out, ack
    );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries; flush wins over push and pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          push,
    input  fetch_entry_t                  push_entry,
    input  logic                          pop,
    output fetch_entry_t                  head,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(FIFO_DEPTH);

    fetch_entry_t    storage [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count_q;
    logic            do_push;
    logic            do_pop;

    // A push into a full queue is only accepted alongside a pop.
    always_comb begin
        do_pop  = pop && !flush && (count_q != '0);
        do_push = push && !flush && ((count_q < DEPTH_W) || do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= push_entry;
        end
    end

    assign head  = storage[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/prefetch_unit.sv
// Decoupled instruction prefetcher: Wishbone classic read master feeding a small queue to decode.
module prefetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    wishbone_if.master  wishbone_bus,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_address,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    fetch_state_t   state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [31:0]    address_q, address_d;
    logic           cycle_q, cycle_d;

    logic [CW-1:0]  count;
    fetch_entry_t   head;
    fetch_entry_t   push_entry;
    logic           push;
    logic           pop;
    logic [CW:0]    occ_pop;
    logic [CW:0]    occ_push_pop;
    logic           ack;

    assign ack     = wishbone_bus.ack;
    assign o_valid = (count != '0);

    always_comb begin
        pop          = o_valid && i_ready;
        push         = (state_q == REQ) && ack && !i_redirect;
        push_entry   = '{pc: fetch_pc_q, instr: wishbone_bus.data_out};
        occ_pop      = {1'b0, count} - {{CW{1'b0}}, pop};
        occ_push_pop = occ_pop + {{CW{1'b0}}, 1'b1};
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        address_d  = address_q;
        cycle_d    = cycle_q;

        case (state_q)
            IDLE: begin
                if (!i_redirect && (occ_pop < DEPTH_W)) begin
                    state_d   = REQ;
                    cycle_d   = 1'b1;
                    address_d = fetch_pc_q;
                end
            end
            REQ: begin
                if (i_redirect) begin
                    // Ack arriving with the redirect closes the cycle; otherwise wait it out.
                    if (ack) begin
                        state_d = IDLE;
                        cycle_d = 1'b0;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (ack) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    if (occ_push_pop < DEPTH_W) begin
                        address_d = fetch_pc_q + 32'd4;
                    end else begin
                        state_d = IDLE;
                        cycle_d = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (ack) begin
                    state_d = IDLE;
                    cycle_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cycle_d = 1'b0;
            end
        endcase

        if (i_redirect) begin
            fetch_pc_d = i_redirect_address & ~32'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_VECTOR;
            address_q  <= RESET_VECTOR;
            cycle_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            address_q  <= address_d;
            cycle_q    <= cycle_d;
        end
    end

    fetch_queue #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (i_redirect),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign wishbone_bus.cycle        = cycle_q;
    assign wishbone_bus.strobe       = cycle_q;
    assign wishbone_bus.write_enable = 1'b0;
    assign wishbone_bus.select       = 4'b1111;
    assign wishbone_bus.data_in      = 32'd0;
    assign wishbone_bus.address      = address_q;

    assign o_instruction = o_valid ? head.instr : 32'd0;
    assign o_pc          = o_valid ? head.pc : 32'd0;

endmodule

// File: doc/prefetch_unit.md
# prefetch_unit

Parametrised instruction prefetcher that replaces single-shot fetch with a decoupled queue. Runs ahead of decode as a Wishbone classic master, buffering up to FIFO_DEPTH instruction/PC pairs. Decode consumes them through a valid/ready handshake. Branch redirects flush the queue and discard any in-flight response.

## Interface
- RESET_VECTOR, 32'h0000_0000: first fetch address after reset; bits [1:0] must be zero.
- FIFO_DEPTH, 4: queue entries; power of two, ≥2.
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- wishbone_bus  wishbone_if.master  —  instruction bus; read-only use.
- i_redirect  input  1  flush and restart fetch at i_redirect_address.
- i_redirect_address  input  32  new fetch PC; bits [1:0] forced to 0 internally.
- i_ready  input  1  decode accepts head entry this cycle.
- o_valid  output  1  head entry valid.
- o_instruction  output  32  head instruction word; 0 when !o_valid.
- o_pc  output  32  address of o_instruction; 0 when !o_valid.

## Operation
- Reset values:
  - Bus outputs: cycle=0, strobe=0, write_enable=0, select=4'b1111, data_in=0, address=RESET_VECTOR.
  - Internal: fetch_pc=RESET_VECTOR, queue empty, state IDLE.
  - Outputs: o_valid=0, o_instruction=0, o_pc=0.
- States:
  - IDLE: no bus cycle in progress. Issue when the queue has space: occupancy after this cycle's pop < FIFO_DEPTH, and no redirect. Issue sets address<=fetch_pc, cycle=strobe=1, and moves to REQ.
  - REQ: cycle/strobe held, address stable until ack. On ack:
    - Push {fetch_pc, data_out} and set fetch_pc<=fetch_pc+4.
    - If space remains after push/pop, stay REQ with address<=fetch_pc+4 (back-to-back). Otherwise drop cycle/strobe and go to IDLE.
  - DRAIN: cycle/strobe held until ack; ack data discarded. Then drop cycle/strobe and go to IDLE.
- Pop: o_valid && i_ready removes the head at the clock edge. Push and pop in the same cycle are legal at any occupancy, including full-with-pop.
- Redirect has priority over push, pop and issue:
  - Queue flushed and fetch_pc<=i_redirect_address&~3.
  - In REQ without ack: go to DRAIN.
  - In REQ with simultaneous ack: data discarded, cycle/strobe dropped, go to IDLE.
  - In IDLE: stay IDLE; issue on the following cycle.
  - In DRAIN: fetch_pc updated, remain DRAIN.
- PC arithmetic: modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- write_enable is never asserted. select is constant 4'b1111.

## Timing
- Reset deasserted at edge 0: cycle/strobe high after edge 1 with address=RESET_VECTOR.
- Ack sampled at edge k: entry visible (o_valid=1) after edge k.
- Back-to-back: one instruction per cycle with a single-cycle-ack slave.
- Redirect sampled at edge r: o_valid=0 after edge r.
  - From IDLE: new request is on the bus after edge r+1.
  - From DRAIN: new request is on the bus one cycle after the discarded ack.
- Full queue: the queue holds exactly FIFO_DEPTH entries. No request is issued until a pop.

## Structure
- Package fetch_pkg holds:
  - fetch_state_t enum {IDLE, REQ, DRAIN}.
  - fetch_entry_t packed struct {pc[31:0], instr[31:0]}.
- Sub-module fetch_queue is a synchronous FIFO of fetch_entry_t. It has FIFO_DEPTH, push, pop and flush, with count output and registered storage. Flush has priority over push.

## Test plan
- Reset, zero-wait slave, i_ready=1, RESET_VECTOR=32'h100 -> o_pc sequence 100,104,108 on consecutive cycles, matching memory words.
- i_ready=0, FIFO_DEPTH=4 -> exactly 4 bus transactions, then cycle=0. One pop -> exactly one new request.
- Redirect to 32'h200 while REQ awaits a 3-cycle-late ack -> that ack's data never appears. First valid entry is o_pc=200.
- Redirect coincident with ack, plus pop of a full queue -> queue empty next cycle. Next request address 32'h200.
- Redirect address 32'h203 -> fetch at 32'h200. Fetch starting at 32'hFFFF_FFF8 -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert reset mid-REQ -> all outputs at reset values next cycle; first new request at RESET_VECTOR.
